icepic_fetch: RTL and testbench
===============================

Name: icepic_fetch

Overview:
- Instruction fetch and program-counter stage of the iCEPIC baseline core. It sits directly upstream of the decode/execute stage.
- It drives a synchronous 12-bit program ROM and presents fetched words, with their addresses, to execute.
- It resolves GOTO, CALL and RETLW locally using a 2-level hardware stack.
- It applies skip and PCL-write requests returned by execute, inserting the one-cycle bubble required by baseline PIC timing.

Parameters:
- PC_W, 9, program counter / ROM address width (512 words).
- RESET_VEC, 9'h1FF, first fetch address after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- prog_addr  output  9  ROM read address (registered)
- prog_en  output  1  ROM read enable; low during stall
- prog_data  input  12  ROM data, valid one cycle after the address is issued
- inst  output  12  instruction word presented to execute
- inst_addr  output  9  address of inst
- inst_valid  output  1  inst is live; low means bubble (treat as NOP)
- stall  input  1  execute cannot accept inst this cycle
- skip_req  input  1  consumed instruction skips the next one (BTFSC/BTFSS/DECFSZ/INCFSZ true)
- pcl_we  input  1  consumed instruction writes PCL
- pcl_data  input  8  value written to PCL
- stack_depth  output  2  occupied stack entries, 0..2 (verification visibility)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: prog_addr=RESET_VEC, prog_en=1, inst=12'h000, inst_addr=0, inst_valid=0, both stack entries=0, stack_depth=0.
- Fetch latency:
  - Address A issued in cycle t → inst=prog_data, inst_addr=A, inst_valid=1 in cycle t+1.
  - The first valid instruction after rst falls appears 1 cycle later at RESET_VEC.
- Consume: an instruction is consumed when inst_valid=1 and stall=0. Redirects and skips act only on consume.
- Sequential: prog_addr <= prog_addr+1, mod 2^PC_W. 9'h1FF wraps to 9'h000.
- Decode, on the consumed inst:
  - GOTO (inst[11:9]=3'b101): target=inst[8:0].
  - CALL (inst[11:8]=4'h9): target={1'b0,inst[7:0]}. Push inst_addr+1.
  - RETLW (inst[11:8]=4'h8): target=pop.
- pcl_we: target={1'b0,pcl_data}.
- Redirect:
  - prog_addr <= target.
  - The word already in flight is squashed (inst_valid=0 next cycle), giving a 2-cycle instruction.
- Skip: skip_req on consume squashes the next presented word (inst_valid=0, inst_addr still shown). Fetch continues sequentially.
- Priority: rst > stall > redirect (GOTO/CALL/RETLW/pcl_we) > skip > sequential.
  - A redirect occurring together with skip_req ignores the skip.
  - Only one redirect source is active per consumed instruction. Execute guarantees this; the bench flags a violation with an assertion.
- Stall:
  - prog_addr, inst, inst_addr and inst_valid are held; prog_en=0.
  - The ROM output is captured in an internal hold register so inst stays stable for any stall length.
  - Stack, skip and redirect state are frozen.
- Stack:
  - Two entries, top and bottom.
  - Push: bottom<=top, top<=value. A push at depth 2 discards the old bottom; depth saturates at 2.
  - Pop: returns top, top<=bottom, bottom unchanged. Depth decrements, saturating at 0. Pop at depth 0 still returns top (stale value, PIC-compatible).
- Reset mid-operation: all in-flight words are squashed, the stack is cleared, and fetch restarts at RESET_VEC in the next cycle.

Test Plan:
- Reset release:
  - Stimulus: ROM[1FF]=C25, ROM[000]=000.
  - Response: inst_valid rises 1 cycle after rst falls with inst=C25, inst_addr=1FF. The next word is inst_addr=000 (wrap).
- GOTO:
  - Stimulus: ROM[010]=A40 (GOTO 040).
  - Response: inst_addr 010 valid, then one bubble (inst_valid=0), then inst_addr=040. Total 2 cycles.
- CALL/RETLW:
  - Stimulus: ROM[020]=930 (CALL 30), ROM[030]=855 (RETLW 55).
  - Response: sequence 020, bubble, 030, bubble, 021. stack_depth goes 0→1→0.
- Stack overflow:
  - Stimulus: nested CALLs from 005, 105, 185 with no return, then three RETLWs.
  - Response: returns go to 186, 106, 106. depth saturates at 2, then 1, then 0.
- Skip:
  - Stimulus: skip_req=1 while consuming 050 (BTFSC).
  - Response: 051 is presented with inst_valid=0, then 052 is valid. With skip_req=0, 051 is valid.
- Stall and PCL write:
  - Stimulus: stall held 3 cycles at inst_addr=060, then pcl_we=1 with pcl_data=8'hF0 on consume.
  - Response: inst, inst_addr and prog_addr are stable for 3 cycles with prog_en=0. After the bubble, inst_addr=0F0 (bit 8 cleared).

Source files
------------

// File: rtl/icepic_fetch.sv
// Fetch/PC stage: drives the synchronous program ROM and presents {inst, inst_addr, inst_valid} to execute.
// Resolves GOTO/CALL/RETLW via a 2-entry stack; skips and PCL writes squash the word in flight.
module icepic_fetch #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_VEC = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] prog_addr,
    output logic            prog_en,
    input  logic [11:0]     prog_data,
    output logic [11:0]     inst,
    output logic [PC_W-1:0] inst_addr,
    output logic            inst_valid,
    input  logic            stall,
    input  logic            skip_req,
    input  logic            pcl_we,
    input  logic [7:0]      pcl_data,
    output logic [1:0]      stack_depth
);

    logic [11:0]     hold;
    logic            use_hold;
    logic [PC_W-1:0] stk_top;
    logic [PC_W-1:0] stk_bot;
    logic            consume;
    logic            is_goto;
    logic            is_call;
    logic            is_retlw;
    logic            redirect;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] next_addr;

    // The hold register covers the stall window and the reset bubble, when the ROM output is not trusted.
    assign inst     = use_hold ? hold : prog_data;
    assign prog_en  = rst | ~stall;

    assign consume  = inst_valid & ~stall;
    assign is_goto  = (inst[11:9] == 3'b101);
    assign is_call  = (inst[11:8] == 4'h9);
    assign is_retlw = (inst[11:8] == 4'h8);
    assign redirect = consume & (is_goto | is_call | is_retlw | pcl_we);

    always_comb begin
        target = prog_addr + 1'b1;
        if (pcl_we)
            target = PC_W'(pcl_data);
        else if (is_goto)
            target = PC_W'(inst[8:0]);
        else if (is_call)
            target = PC_W'(inst[7:0]);
        else if (is_retlw)
            target = stk_top;
    end

    assign next_addr = redirect ? target : prog_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            prog_addr   <= RESET_VEC;
            inst_addr   <= '0;
            inst_valid  <= 1'b0;
            hold        <= 12'h000;
            use_hold    <= 1'b1;
            stk_top     <= '0;
            stk_bot     <= '0;
            stack_depth <= 2'd0;
        end else if (stall) begin
            if (!use_hold)
                hold <= prog_data;
            use_hold <= 1'b1;
        end else begin
            use_hold   <= 1'b0;
            prog_addr  <= next_addr;
            inst_addr  <= prog_addr;
            // The word arriving next cycle is squashed after a redirect or a taken skip.
            inst_valid <= ~(redirect | (consume & skip_req));
            if (consume && is_call && !pcl_we) begin
                stk_bot     <= stk_top;
                stk_top     <= inst_addr + 1'b1;
                stack_depth <= (stack_depth == 2'd2) ? 2'd2 : stack_depth + 2'd1;
            end else if (consume && is_retlw && !pcl_we) begin
                stk_top     <= stk_bot;
                stack_depth <= (stack_depth == 2'd0) ? 2'd0 : stack_depth - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_icepic_fetch.sv
// Directed cycle table for icepic_fetch against a small ROM program, plus reset corner sequences.
module tb_icepic_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  prog_addr;
    logic        prog_en;
    logic [11:0] prog_data;
    logic [11:0] inst;
    logic [8:0]  inst_addr;
    logic        inst_valid;
    logic        stall;
    logic        skip_req;
    logic        pcl_we;
    logic [7:0]  pcl_data;
    logic [1:0]  stack_depth;

    int checks   = 0;
    int failures = 0;

    icepic_fetch #(.PC_W(9), .RESET_VEC(9'h1FF)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_addr   (prog_addr),
        .prog_en     (prog_en),
        .prog_data   (prog_data),
        .inst        (inst),
        .inst_addr   (inst_addr),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .skip_req    (skip_req),
        .pcl_we      (pcl_we),
        .pcl_data    (pcl_data),
        .stack_depth (stack_depth)
    );

    always #5 clk = ~clk;

    // ROM output is deliberately garbage when disabled, so inst must come from the hold register.
    logic [11:0] rom [512];
    always @(posedge clk) prog_data <= prog_en ? rom[prog_addr] : 12'hEEE;

    always @(posedge clk)
        if (!rst && inst_valid && !stall && pcl_we)
            assert (inst[11:10] != 2'b10) else $error("two redirect sources on one instruction");

    typedef struct {
        logic        st;
        logic        sk;
        logic        pw;
        logic [7:0]  pd;
        logic        v;
        logic [8:0]  a;
        logic [11:0] i;
        logic [8:0]  p;
        logic        en;
        logic [1:0]  d;
    } vec_t;

    localparam int NV = 46;
    vec_t tv [NV];

    task automatic check_out(input string name, input logic v, input logic [8:0] a,
                             input logic [11:0] i, input logic [8:0] p, input logic en,
                             input logic [1:0] d);
        checks++;
        if ({inst_valid, inst_addr, inst, prog_addr, prog_en, stack_depth} !== {v, a, i, p, en, d}) begin
            failures++;
            $display("FAIL %s: got v=%b a=%h i=%h p=%h en=%b d=%0d want v=%b a=%h i=%h p=%h en=%b d=%0d",
                     name, inst_valid, inst_addr, inst, prog_addr, prog_en, stack_depth,
                     v, a, i, p, en, d);
        end
    endtask

    // Row 0 is the first cycle after rst falls; each later row is one further clock.
    task automatic run_rows(input int n, input bit chk);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            stall    = tv[k].st;
            skip_req = tv[k].sk;
            pcl_we   = tv[k].pw;
            pcl_data = tv[k].pd;
            #1;
            if (chk)
                check_out($sformatf("row%0d", k), tv[k].v, tv[k].a, tv[k].i, tv[k].p, tv[k].en, tv[k].d);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stall    = 1'b1;
        skip_req = 1'b0;
        pcl_we   = 1'b0;
        pcl_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 512; k++) rom[k] = 12'h000;
        rom[9'h1FF] = 12'hC25;  rom[9'h001] = 12'hA10;  rom[9'h010] = 12'hA40;
        rom[9'h040] = 12'hA20;  rom[9'h020] = 12'h930;  rom[9'h030] = 12'h855;
        rom[9'h021] = 12'hA50;  rom[9'h051] = 12'hA60;  rom[9'h052] = 12'hA50;
        rom[9'h060] = 12'hC33;  rom[9'h0F0] = 12'hA05;  rom[9'h005] = 12'h980;
        rom[9'h080] = 12'hB05;  rom[9'h105] = 12'h990;  rom[9'h090] = 12'hB85;
        rom[9'h185] = 12'h9A0;  rom[9'h0A0] = 12'h800;  rom[9'h186] = 12'h800;
        rom[9'h106] = 12'h800;

        //          st sk pw pd      v  a       i         p       en d
        tv[0]  = '{0, 0, 0, 8'h00, 0, 9'h000, 12'h000, 9'h1FF, 1, 2'd0};
        tv[1]  = '{0, 0, 0, 8'h00, 1, 9'h1FF, 12'hC25, 9'h000, 1, 2'd0};
        tv[2]  = '{0, 0, 0, 8'h00, 1, 9'h000, 12'h000, 9'h001, 1, 2'd0};
        tv[3]  = '{0, 0, 0, 8'h00, 1, 9'h001, 12'hA10, 9'h002, 1, 2'd0};
        tv[4]  = '{0, 0, 0, 8'h00, 0, 9'h002, 12'h000, 9'h010, 1, 2'd0};
        tv[5]  = '{0, 0, 0, 8'h00, 1, 9'h010, 12'hA40, 9'h011, 1, 2'd0};
        tv[6]  = '{0, 0, 0, 8'h00, 0, 9'h011, 12'h000, 9'h040, 1, 2'd0};
        tv[7]  = '{0, 0, 0, 8'h00, 1, 9'h040, 12'hA20, 9'h041, 1, 2'd0};
        tv[8]  = '{0, 0, 0, 8'h00, 0, 9'h041, 12'h000, 9'h020, 1, 2'd0};
        tv[9]  = '{0, 0, 0, 8'h00, 1, 9'h020, 12'h930, 9'h021, 1, 2'd0};
        tv[10] = '{0, 0, 0, 8'h00, 0, 9'h021, 12'hA50, 9'h030, 1, 2'd1};
        tv[11] = '{0, 0, 0, 8'h00, 1, 9'h030, 12'h855, 9'h031, 1, 2'd1};
        tv[12] = '{0, 0, 0, 8'h00, 0, 9'h031, 12'h000, 9'h021, 1, 2'd0};
        tv[13] = '{0, 0, 0, 8'h00, 1, 9'h021, 12'hA50, 9'h022, 1, 2'd0};
        tv[14] = '{0, 0, 0, 8'h00, 0, 9'h022, 12'h000, 9'h050, 1, 2'd0};
        tv[15] = '{0, 1, 0, 8'h00, 1, 9'h050, 12'h000, 9'h051, 1, 2'd0};
        tv[16] = '{0, 0, 0, 8'h00, 0, 9'h051, 12'hA60, 9'h052, 1, 2'd0};
        tv[17] = '{0, 0, 0, 8'h00, 1, 9'h052, 12'hA50, 9'h053, 1, 2'd0};
        tv[18] = '{0, 0, 0, 8'h00, 0, 9'h053, 12'h000, 9'h050, 1, 2'd0};
        tv[19] = '{0, 0, 0, 8'h00, 1, 9'h050, 12'h000, 9'h051, 1, 2'd0};
        tv[20] = '{0, 0, 0, 8'h00, 1, 9'h051, 12'hA60, 9'h052, 1, 2'd0};
        tv[21] = '{0, 0, 0, 8'h00, 0, 9'h052, 12'hA50, 9'h060, 1, 2'd0};
        tv[22] = '{1, 0, 0, 8'h00, 1, 9'h060, 12'hC33, 9'h061, 0, 2'd0};
        tv[23] = '{1, 0, 0, 8'h00, 1, 9'h060, 12'hC33, 9'h061, 0, 2'd0};
        tv[24] = '{1, 0, 0, 8'h00, 1, 9'h060, 12'hC33, 9'h061, 0, 2'd0};
        tv[25] = '{0, 0, 1, 8'hF0, 1, 9'h060, 12'hC33, 9'h061, 1, 2'd0};
        tv[26] = '{0, 0, 0, 8'h00, 0, 9'h061, 12'h000, 9'h0F0, 1, 2'd0};
        tv[27] = '{0, 0, 0, 8'h00, 1, 9'h0F0, 12'hA05, 9'h0F1, 1, 2'd0};
        tv[28] = '{0, 0, 0, 8'h00, 0, 9'h0F1, 12'h000, 9'h005, 1, 2'd0};
        tv[29] = '{0, 0, 0, 8'h00, 1, 9'h005, 12'h980, 9'h006, 1, 2'd0};
        tv[30] = '{0, 0, 0, 8'h00, 0, 9'h006, 12'h000, 9'h080, 1, 2'd1};
        tv[31] = '{0, 0, 0, 8'h00, 1, 9'h080, 12'hB05, 9'h081, 1, 2'd1};
        tv[32] = '{0, 0, 0, 8'h00, 0, 9'h081, 12'h000, 9'h105, 1, 2'd1};
        tv[33] = '{0, 0, 0, 8'h00, 1, 9'h105, 12'h990, 9'h106, 1, 2'd1};
        tv[34] = '{0, 0, 0, 8'h00, 0, 9'h106, 12'h800, 9'h090, 1, 2'd2};
        tv[35] = '{0, 0, 0, 8'h00, 1, 9'h090, 12'hB85, 9'h091, 1, 2'd2};
        tv[36] = '{0, 0, 0, 8'h00, 0, 9'h091, 12'h000, 9'h185, 1, 2'd2};
        tv[37] = '{0, 0, 0, 8'h00, 1, 9'h185, 12'h9A0, 9'h186, 1, 2'd2};
        tv[38] = '{0, 0, 0, 8'h00, 0, 9'h186, 12'h800, 9'h0A0, 1, 2'd2};
        tv[39] = '{0, 0, 0, 8'h00, 1, 9'h0A0, 12'h800, 9'h0A1, 1, 2'd2};
        tv[40] = '{0, 0, 0, 8'h00, 0, 9'h0A1, 12'h000, 9'h186, 1, 2'd1};
        tv[41] = '{0, 0, 0, 8'h00, 1, 9'h186, 12'h800, 9'h187, 1, 2'd1};
        tv[42] = '{0, 0, 0, 8'h00, 0, 9'h187, 12'h000, 9'h106, 1, 2'd0};
        tv[43] = '{0, 0, 0, 8'h00, 1, 9'h106, 12'h800, 9'h107, 1, 2'd0};
        tv[44] = '{0, 0, 0, 8'h00, 0, 9'h107, 12'h000, 9'h106, 1, 2'd0};
        tv[45] = '{0, 0, 0, 8'h00, 1, 9'h106, 12'h800, 9'h107, 1, 2'd0};

        // Reset held with stall high: prog_en must still be asserted.
        rst      = 1'b1;
        stall    = 1'b1;
        skip_req = 1'b0;
        pcl_we   = 1'b0;
        pcl_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_out("in_reset", 1'b0, 9'h000, 12'h000, 9'h1FF, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_rows(NV, 1'b1);

        // Reset while the stack is full and a CALL bubble is in flight.
        do_reset();
        run_rows(35, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_out("midrst_clear", 1'b0, 9'h000, 12'h000, 9'h1FF, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        check_out("midrst_first", 1'b1, 9'h1FF, 12'hC25, 9'h000, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        check_out("midrst_wrap", 1'b1, 9'h000, 12'h000, 9'h001, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
